// File: rtl/dwrr_pkg.sv
// Shared types and helpers for the deficit weighted round-robin scheduler.
// Holds the FSM state encoding, saturating add and modulo-N pointer increment.
package dwrr_pkg;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_SERVE  = 1'b1
    } state_e;

    // Saturates at 2^w-1; callers truncate the result to w bits (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] wrap_inc(input logic [31:0] x,
                                             input logic [31:0] n);
        return (x == n - 32'd1) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

// File: rtl/dwrr_sched_find.sv
// Rotating first-one search starting at ptr (inclusive), wrapping modulo NUM_REQS.
// skip_mask flags the idle requestors passed over before the winner.
module rr_find_first #(
    parameter int NUM_REQS = 4,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] reqs,
    input  logic [CNTWID-1:0]   ptr,
    output logic                found,
    output logic [CNTWID-1:0]   idx,
    output logic [NUM_REQS-1:0] skip_mask
);

    always_comb begin
        int                pos;
        logic [CNTWID-1:0] p;
        found     = 1'b0;
        idx       = '0;
        skip_mask = '0;
        pos       = 0;
        p         = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQS) pos = pos - NUM_REQS;
            p = CNTWID'(pos);
            if (!found) begin
                if (reqs[p]) begin
                    found = 1'b1;
                    idx   = p;
                end else begin
                    skip_mask[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dwrr_sched.sv
// Deficit weighted round-robin scheduler: SELECT credits one quantum to the next
// busy requestor, SERVE grants its head packets while the deficit covers them.
module dwrr_sched
    import dwrr_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 8,
    parameter int DWID     = QWID + 1,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk,
    input  logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS*LWID-1:0] req_len,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [CNTWID-1:0]        gnt_idx,
    output logic [NUM_REQS*DWID-1:0] deficits
);

    state_e              state_q, state_d;
    logic [CNTWID-1:0]   ptr_q, ptr_d;
    logic [DWID-1:0]     def_q [NUM_REQS];
    logic [DWID-1:0]     def_d [NUM_REQS];
    logic [LWID-1:0]     len_arr [NUM_REQS];
    logic [QWID-1:0]     qnt_arr [NUM_REQS];

    logic                found;
    logic [CNTWID-1:0]   find_idx;
    logic [NUM_REQS-1:0] skip_mask;
    logic [DWID-1:0]     cur_len;
    logic                eligible;

    rr_find_first #(
        .NUM_REQS (NUM_REQS),
        .CNTWID   (CNTWID)
    ) u_find (
        .reqs      (reqs),
        .ptr       (ptr_q),
        .found     (found),
        .idx       (find_idx),
        .skip_mask (skip_mask)
    );

    always_comb begin
        deficits = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            len_arr[i]                 = req_len[i*LWID +: LWID];
            qnt_arr[i]                 = input_quantums[i*QWID +: QWID];
            deficits[i*DWID +: DWID]   = def_q[i];
        end
    end

    // A zero-length head packet still costs one unit so it cannot stall the flow.
    always_comb begin
        cur_len  = (len_arr[ptr_q] == '0) ? DWID'(1) : DWID'(len_arr[ptr_q]);
        eligible = reqs[ptr_q] && (def_q[ptr_q] >= cur_len);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        def_d   = def_q;
        gnt     = '0;
        gnt_idx = ptr_q;
        case (state_q)
            ST_SELECT: begin
                if (found) begin
                    for (int i = 0; i < NUM_REQS; i++) begin
                        if (skip_mask[i]) def_d[i] = '0;
                    end
                    def_d[find_idx] = DWID'(sat_add(32'(def_q[find_idx]),
                                                    32'(qnt_arr[find_idx]), DWID));
                    ptr_d   = find_idx;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!reqs[ptr_q]) begin
                    def_d[ptr_q] = '0;
                    ptr_d        = CNTWID'(wrap_inc(32'(ptr_q), 32'(NUM_REQS)));
                    state_d      = ST_SELECT;
                end else if (eligible) begin
                    gnt[ptr_q] = 1'b1;
                    if (!blk) def_d[ptr_q] = def_q[ptr_q] - cur_len;
                end else begin
                    ptr_d   = CNTWID'(wrap_inc(32'(ptr_q), 32'(NUM_REQS)));
                    state_d = ST_SELECT;
                end
            end
            default: state_d = ST_SELECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SELECT;
            ptr_q   <= '0;
            for (int i = 0; i < NUM_REQS; i++) def_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < NUM_REQS; i++) def_q[i] <= def_d[i];
        end
    end

endmodule

// File: tb/tb_dwrr_sched.sv
// Directed testbench for dwrr_sched: a 4-requestor instance for the main scenarios
// and a 3-requestor instance for non-power-of-2 pointer wrap.
module tb_dwrr_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, blk;
    logic [3:0]  reqs4;
    logic [31:0] len4, q4;
    logic [3:0]  gnt4;
    logic [1:0]  idx4;
    logic [35:0] defs4;
    logic [2:0]  reqs3;
    logic [23:0] len3, q3;
    logic [2:0]  gnt3;
    logic [1:0]  idx3;
    logic [26:0] defs3;

    int checks = 0;
    int errors = 0;

    dwrr_sched #(.NUM_REQS(4)) dut4 (
        .clk(clk), .rst(rst), .blk(blk), .reqs(reqs4), .req_len(len4),
        .input_quantums(q4), .gnt(gnt4), .gnt_idx(idx4), .deficits(defs4)
    );

    dwrr_sched #(.NUM_REQS(3)) dut3 (
        .clk(clk), .rst(rst), .blk(blk), .reqs(reqs3), .req_len(len3),
        .input_quantums(q3), .gnt(gnt3), .gnt_idx(idx3), .deficits(defs3)
    );

    function automatic logic [8:0] d4(input int i);
        return defs4[i*9 +: 9];
    endfunction

    function automatic logic [8:0] d3(input int i);
        return defs3[i*9 +: 9];
    endfunction

    // Ends on a falling edge with reset released; the next rising edge is the first active one.
    task automatic reset_all();
        @(negedge clk);
        rst = 1'b0; blk = 1'b0;
        reqs4 = '0; len4 = '0; q4 = '0;
        reqs3 = '0; len3 = '0; q3 = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; blk = 1'b0;
        reqs4 = '0; len4 = '0; q4 = '0;
        reqs3 = '0; len3 = '0; q3 = '0;
        #2 rst = 1'b0;
        #1;
        checks++; if (gnt4 !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt4); end
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx4); end
        checks++; if (defs4 !== 36'd0) begin errors++; $display("FAIL reset_defs got %h exp 0", defs4); end
        checks++; if (gnt3 !== 3'b0 || defs3 !== 27'd0) begin errors++; $display("FAIL reset_dut3 got gnt %b defs %h exp 0", gnt3, defs3); end
    endtask

    task automatic test_reset_mid_serve();
        reset_all();
        reqs4 = 4'b0100; q4 = {8'd0, 8'd12, 8'd0, 8'd0}; len4 = {8'd0, 8'd4, 8'd0, 8'd0};
        @(negedge clk);
        checks++; if (gnt4 !== 4'b0100 || d4(2) !== 9'd12) begin errors++; $display("FAIL mid_setup got gnt %b def2 %0d exp 0100 12", gnt4, d4(2)); end
        blk = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (gnt4 !== 4'b0) begin errors++; $display("FAIL mid_async_gnt got %b exp 0000", gnt4); end
        checks++; if (defs4 !== 36'd0) begin errors++; $display("FAIL mid_async_defs got %h exp 0", defs4); end
        @(negedge clk);
        rst = 1'b1; blk = 1'b0;
        reqs4 = 4'b0101; q4 = {8'd0, 8'd12, 8'd0, 8'd8}; len4 = {8'd0, 8'd4, 8'd0, 8'd4};
        checks++; if (gnt4 !== 4'b0 || idx4 !== 2'd0) begin errors++; $display("FAIL mid_release got gnt %b idx %0d exp 0000 0", gnt4, idx4); end
        @(negedge clk);
        checks++; if (gnt4 !== 4'b0001 || idx4 !== 2'd0) begin errors++; $display("FAIL mid_ptr0 got gnt %b idx %0d exp 0001 0", gnt4, idx4); end
        checks++; if (d4(0) !== 9'd8 || d4(2) !== 9'd0) begin errors++; $display("FAIL mid_defs got d0 %0d d2 %0d exp 8 0", d4(0), d4(2)); end
    endtask

    task automatic test_single_flow();
        logic       exp_g [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0] exp_d [8] = '{9'd0, 9'd8, 9'd4, 9'd0, 9'd0, 9'd8, 9'd4, 9'd0};
        reset_all();
        reqs4 = 4'b0001; q4 = {24'd0, 8'd8}; len4 = {24'd0, 8'd4};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (gnt4 !== (exp_g[k] ? 4'b0001 : 4'b0000) || d4(0) !== exp_d[k]) begin
                errors++; $display("FAIL single_c%0d got gnt %b d0 %0d exp g %b d0 %0d", k, gnt4, d4(0), exp_g[k], exp_d[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_len();
        logic [8:0] exp_d [3] = '{9'd2, 9'd1, 9'd0};
        logic       exp_g [3] = '{1'b1, 1'b1, 1'b0};
        reset_all();
        reqs4 = 4'b0001; q4 = {24'd0, 8'd2}; len4 = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (gnt4 !== (exp_g[k] ? 4'b0001 : 4'b0000) || d4(0) !== exp_d[k]) begin
                errors++; $display("FAIL zlen_c%0d got gnt %b d0 %0d exp g %b d0 %0d", k, gnt4, d4(0), exp_g[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_weighting();
        logic [1:0] exp_o [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        logic [1:0] got [9];
        int n = 0;
        int tot = 0;
        reset_all();
        reqs4 = 4'b0011; q4 = {8'd0, 8'd0, 8'd8, 8'd16}; len4 = {8'd8, 8'd8, 8'd8, 8'd8};
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (gnt4 != 4'b0 && !blk) begin
                if (n < 9) begin got[n] = idx4; n++; end
                tot++;
            end
        end
        checks++; if (tot != 14) begin errors++; $display("FAIL weight_total got %0d exp 14", tot); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (k >= n || got[k] !== exp_o[k]) begin
                errors++; $display("FAIL weight_order%0d got %0d (of %0d) exp %0d", k, got[k], n, exp_o[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        reset_all();
        reqs4 = 4'b0010; q4 = {16'd0, 8'd8, 8'd0}; len4 = {16'd0, 8'd8, 8'd0};
        @(negedge clk);
        checks++; if (gnt4 !== 4'b0010 || idx4 !== 2'd1 || d4(1) !== 9'd8) begin errors++; $display("FAIL bp_setup got gnt %b idx %0d d1 %0d exp 0010 1 8", gnt4, idx4, d4(1)); end
        blk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (gnt4 !== 4'b0010 || idx4 !== 2'd1 || d4(1) !== 9'd8) begin
                errors++; $display("FAIL bp_hold%0d got gnt %b idx %0d d1 %0d exp 0010 1 8", k, gnt4, idx4, d4(1));
            end
        end
        blk = 1'b0;
        @(negedge clk);
        checks++; if (d4(1) !== 9'd0 || gnt4 !== 4'b0) begin errors++; $display("FAIL bp_accept got gnt %b d1 %0d exp 0000 0", gnt4, d4(1)); end
    endtask

    task automatic test_large_packet();
        logic       exp_g [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] exp_d [6] = '{9'd8, 9'd8, 9'd16, 9'd16, 9'd24, 9'd4};
        reset_all();
        reqs4 = 4'b0100; q4 = {8'd0, 8'd8, 16'd0}; len4 = {8'd0, 8'd20, 16'd0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (gnt4 !== (exp_g[k] ? 4'b0100 : 4'b0000) || d4(2) !== exp_d[k]) begin
                errors++; $display("FAIL large_c%0d got gnt %b d2 %0d exp g %b d2 %0d", k, gnt4, d4(2), exp_g[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_zero_quantum();
        reset_all();
        reqs4 = 4'b0010; q4 = 32'd0; len4 = {16'd0, 8'd4, 8'd0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (gnt4 !== 4'b0 || d4(1) !== 9'd0) begin
                errors++; $display("FAIL zq_c%0d got gnt %b d1 %0d exp 0000 0", k, gnt4, d4(1));
            end
        end
    endtask

    task automatic test_wrap3();
        logic [2:0] exp_g [5] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
        logic [1:0] exp_i [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        logic [8:0] exp_d [5] = '{9'd0, 9'd4, 9'd0, 9'd0, 9'd4};
        reset_all();
        reqs3 = 3'b100; q3 = {8'd5, 16'd0}; len3 = {8'd8, 16'd0};
        @(negedge clk);
        checks++; if (gnt3 !== 3'b0 || idx3 !== 2'd2 || d3(2) !== 9'd5) begin errors++; $display("FAIL wrap_setup got gnt %b idx %0d d2 %0d exp 000 2 5", gnt3, idx3, d3(2)); end
        reqs3 = 3'b001; q3 = {8'd5, 8'd0, 8'd4}; len3 = {8'd8, 8'd0, 8'd4};
        @(negedge clk);
        checks++; if (d3(2) !== 9'd0) begin errors++; $display("FAIL wrap_clear got d2 %0d exp 0", d3(2)); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (gnt3 !== exp_g[k] || idx3 !== exp_i[k] || d3(0) !== exp_d[k]) begin
                errors++; $display("FAIL wrap_c%0d got gnt %b idx %0d d0 %0d exp %b %0d %0d", k, gnt3, idx3, d3(0), exp_g[k], exp_i[k], exp_d[k]);
            end
            checks++;
            if (idx3 === 2'd3) begin errors++; $display("FAIL wrap_range%0d got idx %0d exp <3", k, idx3); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_serve();
        test_single_flow();
        test_zero_len();
        test_weighting();
        test_back_pressure();
        test_large_packet();
        test_zero_quantum();
        test_wrap3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwrr_sched.md
Name: dwrr_sched

Overview:
- Parametrised deficit weighted round-robin scheduler; successor to the fixed-size DWRR arbiter.
- Adds variable per-requestor packet lengths and work-conserving skip of idle requestors in a single SELECT cycle.
- Adds saturating deficit arithmetic, non-power-of-2 requestor counts and a blk (back-pressure) accept handshake.
- Sits between per-flow request queues and a shared downstream link; one grant at a time.

Parameters:
- NUM_REQS, 4, number of requestors (>=2, any value, not only powers of 2)
- QWID, 8, width of each per-requestor quantum
- LWID, 8, width of each head-packet length
- DWID, QWID+1, deficit counter width (must be >= max(QWID, LWID))
- CNTWID, $clog2(NUM_REQS), pointer/index width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- blk  in  1  downstream blocked; a grant is accepted on a cycle with gnt!=0 and blk=0
- reqs  in  NUM_REQS  requestor i has a head packet pending
- req_len  in  NUM_REQS*LWID  head-packet length of requestor i, at slice [(i+1)*LWID-1 : i*LWID]
- input_quantums  in  NUM_REQS*QWID  quantum of requestor i, same packing; sampled when added
- gnt  out  NUM_REQS  one-hot grant
- gnt_idx  out  CNTWID  index of the granted requestor; valid when |gnt
- deficits  out  NUM_REQS*DWID  current deficit counters, same packing (debug/verification)

Behaviour:
- Reset (rst=0, async): state=SELECT, ptr=0, all deficits=0, gnt=0, gnt_idx=0; takes effect immediately, including mid-SERVE.
- State machine: SELECT, SERVE.
- SELECT:
  - Rotating search from ptr inclusive, wrapping modulo NUM_REQS, for the first i with reqs[i]=1.
  - If none: remain in SELECT; ptr and deficits unchanged.
  - If found at j:
    - def[j] <= sat(def[j] + quantum[j]), saturating at 2^DWID-1.
    - Every requestor visited before j in the search (reqs=0) gets def <= 0.
    - ptr <= j; next state SERVE.
  - gnt=0 throughout SELECT.
- SERVE, with L = req_len[ptr] and L=0 treated as 1:
  - eligible = reqs[ptr] & (def[ptr] >= L).
  - gnt = onehot(ptr) when eligible, else 0; gnt_idx = ptr.
  - eligible and blk=0: def[ptr] <= def[ptr] - L; remain in SERVE. The next head packet is evaluated next cycle, giving back-to-back grants.
  - eligible and blk=1: hold. gnt, gnt_idx and def are unchanged; req_len must stay stable while gnt is held.
  - reqs[ptr]=0: def[ptr] <= 0; ptr <= wrap(ptr+1); next state SELECT.
  - reqs[ptr]=1 and def[ptr] < L: keep def (carry-over); ptr <= wrap(ptr+1); next state SELECT.
- wrap(x) = (x == NUM_REQS-1) ? 0 : x+1; never produce an index >= NUM_REQS.
- Latency: from reqs rising at an idle scheduler in SELECT, gnt asserts in the following cycle.
- quantum=0: the requestor is visited, cannot be granted unless it already holds deficit, and is then skipped.
- gnt is at most one-hot at all times; gnt[i]=1 implies reqs[i]=1.
- Deficits of non-selected, non-skipped requestors never change.
- Comparisons and subtraction are unsigned at DWID bits; L is zero-extended.

Decomposition:
- Shared package dwrr_pkg:
  - State enum (SELECT, SERVE).
  - Saturating-add function.
  - wrap-increment function, parametrised by NUM_REQS.
- One sub-module, rr_find_first:
  - Combinational rotating priority search.
  - Inputs: reqs, ptr.
  - Outputs: found, idx, and a skipped-mask of the empty requestors between ptr and idx.

Test Plan:
1. Reset mid-SERVE: gnt[2]=1 with def[2]=12, drive rst=0 asynchronously -> gnt=0, deficits=0 before the next edge; after release, state=SELECT and ptr=0.
2. Single flow: reqs=0001, q0=8, len=4, blk=0 -> SELECT, gnt[0], gnt[0], SELECT, ... repeating; deficits[0] reads 8, 4, 0.
3. Weighting: reqs=0011, q0=16, q1=8, len=8 -> steady-state accepted-grant order 0,0,1,0,0,1; 2:1 ratio.
4. Back-pressure: gnt[1]=1 with def[1]=8, len=8, blk=1 for 3 cycles -> gnt and gnt_idx=1 stable, def[1]=8. blk=0 -> one accept, then def[1]=0.
5. Large packet: reqs=0100, q2=8, len2=20 -> def[2] accumulates 8, 16, 24 on successive visits with no grant; granted on the third visit, leaving def[2]=4.
6. NUM_REQS=3 wrap: ptr=2, reqs=001 with def[2]=5 and reqs[2]=0 -> def[2] cleared, search wraps to 0 in one SELECT cycle, gnt_idx never equals 3.
